nonce_scheduler: RTL and testbench

//  Top-level mining sequencer. Drives the hashing module over an inclusive nonce range:

---
 rtl/miner_pkg.sv | 9 +
 rtl/nonce_counter.sv | 28 ++
 rtl/nonce_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_nonce_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared mining typedefs: scheduler state encoding and default datapath widths.
package miner_pkg;
  localparam int NONCE_W_DEF = 32;
  localparam int HASH_W_DEF  = 256;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_FINISH, S_QUIT
  } sched_state_t;
endpackage

// File: rtl/nonce_counter.sv
// Nonce register with load, wrapping increment, and last-nonce compare.
module nonce_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] end_val,
  output logic [W-1:0] nonce,
  output logic         is_last
);
  logic [W-1:0] nonce_d, nonce_q;

  always_comb begin
    nonce_d = nonce_q;
    if (load)     nonce_d = load_val;
    else if (inc) nonce_d = nonce_q + W'(1);
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) nonce_q <= '0;
    else        nonce_q <= nonce_d;

  assign nonce   = nonce_q;
  assign is_last = (nonce_q == end_val);
endmodule

// File: rtl/nonce_scheduler.sv
// Mining sequencer: walks an inclusive nonce range through the hashing module,
// stops on the first digest below target. MINER_WATCHDOG_EN adds a WAIT timeout.
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int HASH_W  = HASH_W_DEF
`ifdef MINER_WATCHDOG_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic [HASH_W-1:0]  target,
  input  logic               hash_done,
  input  logic [HASH_W-1:0]  hash_out,
  output logic               begin_hash,
  output logic               quit_hash,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] golden_nonce,
`ifdef MINER_WATCHDOG_EN
  output logic               timeout_err,
`endif
  output logic [NONCE_W-1:0] hash_count
);
  sched_state_t       state_d, state_q;
  logic [NONCE_W-1:0] start_d, start_q, end_d, end_q;
  logic [HASH_W-1:0]  target_d, target_q, hash_reg_d, hash_reg_q;
  logic [NONCE_W-1:0] golden_d, golden_q, count_d, count_q;
  logic               found_d, found_q;
  logic               begin_d, begin_q, quit_d, quit_q, done_d, done_q, busy_d, busy_q;
  logic               ctr_load, ctr_inc, is_last;
`ifdef MINER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_d, wd_q;
  logic            tmo_d, tmo_q;
`endif

  nonce_counter #(.W(NONCE_W)) u_ctr (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (ctr_load),
    .inc      (ctr_inc),
    .load_val (start_q),
    .end_val  (end_q),
    .nonce    (nonce),
    .is_last  (is_last)
  );

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    end_d      = end_q;
    target_d   = target_q;
    hash_reg_d = hash_reg_q;
    golden_d   = golden_q;
    count_d    = count_q;
    found_d    = found_q;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
`ifdef MINER_WATCHDOG_EN
    wd_d  = wd_q;
    tmo_d = tmo_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_LOAD;
        start_d  = nonce_start;
        end_d    = nonce_end;
        target_d = target;
        found_d  = 1'b0;
        golden_d = '0;
        count_d  = '0;
`ifdef MINER_WATCHDOG_EN
        tmo_d    = 1'b0;
`endif
      end
      S_LOAD: begin
        ctr_load = 1'b1;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MINER_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        if (hash_done) begin
          hash_reg_d = hash_out;
          count_d    = count_q + NONCE_W'(1);
          state_d    = S_CHECK;
        end
`ifdef MINER_WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_QUIT;
          tmo_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_CHECK: begin
        if (hash_reg_q < target_q) begin
          found_d  = 1'b1;
          golden_d = nonce;
          state_d  = S_FINISH;
        end else if (is_last) begin
          state_d = S_FINISH;
        end else begin
          ctr_inc = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_QUIT:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides everything in the active states, including a same-cycle
    // hash_done: the in-flight result is dropped, not counted.
    if (abort && (state_q inside {S_LOAD, S_ISSUE, S_WAIT, S_CHECK})) begin
      state_d    = S_QUIT;
      ctr_load   = 1'b0;
      ctr_inc    = 1'b0;
      hash_reg_d = hash_reg_q;
      count_d    = count_q;
      found_d    = found_q;
      golden_d   = golden_q;
`ifdef MINER_WATCHDOG_EN
      tmo_d      = tmo_q;
`endif
    end

    // Outputs are registered decodes of the next state.
    begin_d = (state_d == S_ISSUE);
    quit_d  = (state_d == S_QUIT);
    done_d  = (state_d == S_FINISH);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      start_q    <= '0;
      end_q      <= '0;
      target_q   <= '0;
      hash_reg_q <= '0;
      golden_q   <= '0;
      count_q    <= '0;
      found_q    <= 1'b0;
      begin_q    <= 1'b0;
      quit_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MINER_WATCHDOG_EN
      wd_q       <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      end_q      <= end_d;
      target_q   <= target_d;
      hash_reg_q <= hash_reg_d;
      golden_q   <= golden_d;
      count_q    <= count_d;
      found_q    <= found_d;
      begin_q    <= begin_d;
      quit_q     <= quit_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef MINER_WATCHDOG_EN
      wd_q       <= wd_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign begin_hash   = begin_q;
  assign quit_hash    = quit_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign found        = found_q;
  assign golden_nonce = golden_q;
  assign hash_count   = count_q;
`ifdef MINER_WATCHDOG_EN
  assign timeout_err  = tmo_q;
`endif
endmodule

// File: tb/tb_nonce_scheduler.sv
// Randomized bench for nonce_scheduler; the bench plays the hashing module and
// checks against a range-walk reference model.
module tb_nonce_scheduler;
  localparam int NW = 32;
  localparam int HW = 256;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0, abort = 1'b0, hash_done = 1'b0;
  logic [NW-1:0] nonce_start = '0, nonce_end = '0;
  logic [HW-1:0] target = '0, hash_out = '0;
  logic          begin_hash, quit_hash, busy, done, found;
  logic [NW-1:0] nonce, golden_nonce, hash_count;
`ifdef MINER_WATCHDOG_EN
  logic          timeout_err;
`endif

  int checks = 0;
  int failures = 0;

  logic [HW-1:0] hq[$];
  logic [NW-1:0] exp_n[$];
  logic [NW-1:0] obs_n[$];

  nonce_scheduler #(
    .NONCE_W(NW), .HASH_W(HW)
`ifdef MINER_WATCHDOG_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .hash_done(hash_done), .hash_out(hash_out),
    .begin_hash(begin_hash), .quit_hash(quit_hash), .nonce(nonce),
    .busy(busy), .done(done), .found(found), .golden_nonce(golden_nonce),
`ifdef MINER_WATCHDOG_EN
    .timeout_err(timeout_err),
`endif
    .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] rand256();
    logic [HW-1:0] r;
    for (int i = 0; i < HW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Target in [2^254, 2^255): small offsets either side never overflow.
  function automatic logic [HW-1:0] rand_target();
    logic [HW-1:0] t;
    t = rand256();
    t[HW-1] = 1'b0;
    t[HW-2] = 1'b1;
    return t;
  endfunction

  // Runs one search; the bench answers begin_hash with hashes from hq in order.
  task automatic run_search(input string name, input logic [NW-1:0] s, input logic [NW-1:0] e,
                            input logic [HW-1:0] t, input bit inject_start);
    int nb = 0, nd = 0, nq = 0, pend = 0, idx = 0, cyc = 0;
    bit  m_found = 0;
    logic [NW-1:0] m_gold = '0, n;
    int  m_cnt = 0;
    // Reference: walk nonces s, s+1, ... (mod 2^NW) until a hit or e.
    exp_n.delete();
    obs_n.delete();
    for (int i = 0; i < hq.size(); i++) begin
      n = s + NW'(i);
      exp_n.push_back(n);
      m_cnt++;
      if (hq[i] < t) begin m_found = 1; m_gold = n; break; end
      if (n == e) break;
    end

    @(negedge clk);
    start = 1'b1; nonce_start = s; nonce_end = e; target = t;
    @(negedge clk);
    start = 1'b0; nonce_start = $urandom; nonce_end = $urandom; target = rand256();
    while (cyc < 500) begin
      hash_done = 1'b0;
      start = 1'b0;
      if (quit_hash) nq++;
      if (begin_hash) begin
        nb++;
        obs_n.push_back(nonce);
        pend = $urandom_range(1, 4);
      end else if (pend > 0) begin
        pend--;
        if (inject_start && nb == 2 && pend == 1) start = 1'b1;
        if (pend == 0) begin
          hash_done = 1'b1;
          hash_out = (idx < hq.size()) ? hq[idx] : rand256();
          idx++;
        end
      end
      if (done) begin nd++; break; end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) begin
      failures++;
      $display("FAIL %s timeout: no done within 500 cycles", name);
    end
    checks++;
    if (nb !== m_cnt) begin failures++; $display("FAIL %s begin_hash count: got %0d want %0d", name, nb, m_cnt); end
    for (int i = 0; i < obs_n.size() && i < exp_n.size(); i++) begin
      checks++;
      if (obs_n[i] !== exp_n[i]) begin failures++; $display("FAIL %s nonce[%0d]: got %h want %h", name, i, obs_n[i], exp_n[i]); end
    end
    checks++;
    if (found !== m_found) begin failures++; $display("FAIL %s found: got %b want %b", name, found, m_found); end
    if (m_found) begin
      checks++;
      if (golden_nonce !== m_gold) begin failures++; $display("FAIL %s golden: got %h want %h", name, golden_nonce, m_gold); end
    end
    checks++;
    if (hash_count !== NW'(m_cnt)) begin failures++; $display("FAIL %s hash_count: got %0d want %0d", name, hash_count, m_cnt); end
    checks++;
    if (nq !== 0) begin failures++; $display("FAIL %s quit_hash: got %0d pulses want 0", name, nq); end
    hash_done = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s post done/busy: got %b/%b want 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({begin_hash, quit_hash, busy, done, found} !== 5'b0 || nonce !== '0 ||
        golden_nonce !== '0 || hash_count !== '0) begin
      failures++;
      $display("FAIL reset outputs: got bh=%b qh=%b busy=%b done=%b found=%b nonce=%h gold=%h cnt=%0d want all 0",
               begin_hash, quit_hash, busy, done, found, nonce, golden_nonce, hash_count);
    end
`ifdef MINER_WATCHDOG_EN
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset timeout_err: got %b want 0", timeout_err); end
`endif
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [HW-1:0] t = rand_target();
    hq = '{t - 256'd5};
    run_search("single_hit", 32'd5, 32'd5, t, 0);
  endtask

  task automatic test_no_hit();
    logic [HW-1:0] t = rand_target();
    hq.delete();
    for (int i = 0; i < 4; i++) hq.push_back(t + HW'($urandom_range(0, 999)));
    run_search("no_hit", 32'd10, 32'd13, t, 0);
  endtask

  task automatic test_wrap();
    logic [HW-1:0] t = rand_target();
    hq = '{t + 256'd1, t, t - 256'd1, t - 256'd2};
    run_search("wrap", 32'hFFFF_FFFE, 32'h1, t, 0);
  endtask

  task automatic test_equal_boundary();
    logic [HW-1:0] t = rand_target();
    hq = '{t, t - 256'd1};
    run_search("equal_boundary", 32'd20, 32'd21, t, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [HW-1:0] t = rand_target();
      logic [NW-1:0] s = $urandom;
      int len = $urandom_range(1, 6);
      int hit = $urandom_range(0, 7);
      hq.delete();
      for (int i = 0; i < len; i++)
        hq.push_back((i == hit) ? t - HW'($urandom_range(1, 999)) : t + HW'($urandom_range(0, 999)));
      run_search($sformatf("random%0d", k), s, s + NW'(len - 1), t, k[0]);
    end
  endtask

  task automatic test_abort();
    int nq = 0, nd = 0, cyc = 0;
    // Abort in IDLE is ignored.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || quit_hash !== 1'b0) begin
      failures++; $display("FAIL abort_idle: got busy=%b quit=%b want 0/0", busy, quit_hash);
    end
    start = 1'b1; nonce_start = 32'd100; nonce_end = 32'd110; target = rand_target();
    @(negedge clk); start = 1'b0;
    while (!begin_hash && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    // Now in WAIT: hash_done and abort together, hash would be a hit.
    hash_done = 1'b1; hash_out = '0; abort = 1'b1;
    @(negedge clk);
    hash_done = 1'b0; abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (quit_hash) nq++;
      if (done) nd++;
      @(negedge clk);
    end
    checks++;
    if (nq !== 1) begin failures++; $display("FAIL abort quit_hash: got %0d pulses want 1", nq); end
    checks++;
    if (nd !== 0) begin failures++; $display("FAIL abort done: got %0d pulses want 0", nd); end
    checks++;
    if (found !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort end state: got found=%b busy=%b want 0/0", found, busy);
    end
  endtask

`ifdef MINER_WATCHDOG_EN
  task automatic test_watchdog();
    int cyc = 0, dist = 0;
    @(negedge clk);
    start = 1'b1; nonce_start = 32'd0; nonce_end = 32'd3; target = rand_target();
    @(negedge clk); start = 1'b0;
    while (!begin_hash && cyc < 20) begin @(negedge clk); cyc++; end
    while (!quit_hash && dist < 100) begin @(negedge clk); dist++; end
    checks++;
    if (dist !== 17) begin failures++; $display("FAIL watchdog latency: got %0d want 17 (16 after WAIT entry)", dist); end
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL watchdog timeout_err: got %b want 1", timeout_err); end
    @(negedge clk);
    start = 1'b1; nonce_start = 32'd7; nonce_end = 32'd7;
    @(negedge clk); start = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL watchdog clear: got %b want 0", timeout_err); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_no_hit();
    test_wrap();
    test_equal_boundary();
    test_random();
    test_abort();
`ifdef MINER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
